// File: rtl/dmux_4_way.sv
// Eight-way channel selector: routes one of a..h to o under a 3-bit select.
// The output is either registered (1-cycle latency) or purely combinational.
module dmux_4_way #(
   parameter int WIDTH        = 1,
   parameter bit REGISTER_OUT = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [2:0]       sel,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [WIDTH-1:0] d,
   input  logic [WIDTH-1:0] e,
   input  logic [WIDTH-1:0] f,
   input  logic [WIDTH-1:0] g,
   input  logic [WIDTH-1:0] h,
   output logic [WIDTH-1:0] o
);

   logic [WIDTH-1:0] next_val;

   always_comb begin
      // NOTE: assign a default before the case so no path can infer a latch.
      next_val = {WIDTH{1'bx}};
      case (sel)
         3'd0:    next_val = a;
         3'd1:    next_val = b;
         3'd2:    next_val = c;
         3'd3:    next_val = d;
         3'd4:    next_val = e;
         3'd5:    next_val = f;
         3'd6:    next_val = g;
         3'd7:    next_val = h;
         default: next_val = {WIDTH{1'bx}};  // X on sel propagates to o
      endcase
   end

   generate
      if (REGISTER_OUT) begin : g_reg
         always_ff @(posedge clk or negedge rst_n) begin
            // NOTE: non-blocking assignment for registered state avoids ordering races.
            if (!rst_n) o <= '0;
            else        o <= next_val;
         end
      end else begin : g_comb
         // Clock and reset are not needed; fold them into a sink so they stay connected.
         logic unused_clk_rst;
         assign unused_clk_rst = &{1'b0, clk, rst_n};
         assign o = next_val;
      end
   endgenerate

endmodule

// File: tb/tb_dmux_4_way.sv
// Self-checking bench for dmux_4_way: a registered WIDTH=1 instance and a
// combinational WIDTH=4 instance, checked against an array-indexed model.
module tb_dmux_4_way;

   logic       clk;
   logic       rst_n;
   logic [2:0] sel;
   logic       ch [8];
   logic       o;

   logic [2:0] csel;
   logic [3:0] cch [8];
   logic [3:0] co;

   int vectors;
   int miscompares;

   dmux_4_way #(.WIDTH(1), .REGISTER_OUT(1'b1)) dut_reg (
      .clk(clk), .rst_n(rst_n), .sel(sel),
      .a(ch[0]), .b(ch[1]), .c(ch[2]), .d(ch[3]),
      .e(ch[4]), .f(ch[5]), .g(ch[6]), .h(ch[7]),
      .o(o)
   );

   dmux_4_way #(.WIDTH(4), .REGISTER_OUT(1'b0)) dut_comb (
      .clk(clk), .rst_n(rst_n), .sel(csel),
      .a(cch[0]), .b(cch[1]), .c(cch[2]), .d(cch[3]),
      .e(cch[4]), .f(cch[5]), .g(cch[6]), .h(cch[7]),
      .o(co)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Model: the registered output after an edge is the channel named by sel before it.
   task automatic step(input string tag);
      logic expv;
      expv = ch[sel];
      @(posedge clk);
      #1;
      check(tag, {3'b0, o}, {3'b0, expv});
   endtask

   task automatic set_channels(input logic [7:0] bits);
      for (int i = 0; i < 8; i++) ch[i] = bits[i];
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      csel        = 3'd0;
      for (int i = 0; i < 8; i++) cch[i] = 4'h0;

      // Reset with all channels high: o must read 0 before any clock edge.
      rst_n = 1'b0;
      sel   = 3'd0;
      set_channels(8'hFF);
      #2;
      check("reset_immediate", {3'b0, o}, 4'h0);
      repeat (2) @(posedge clk);
      #1;
      check("reset_hold", {3'b0, o}, 4'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("reset_release_no_edge", {3'b0, o}, 4'h0);
      step("first_capture");

      // Sweep: a..h = 1,0,1,0,0,1,1,0, sel 0..7.
      set_channels(8'b0110_0101);
      for (int s = 0; s < 8; s++) begin
         sel = 3'(s);
         step($sformatf("sweep_sel%0d", s));
      end

      // Wrap 7 -> 0 with h=1, a=0.
      ch[7] = 1'b1;
      ch[0] = 1'b0;
      sel   = 3'd7;
      step("wrap_h");
      sel = 3'd0;
      step("wrap_a");

      // Toggle d with everything else held high.
      set_channels(8'hFF);
      sel = 3'd3;
      for (int i = 0; i < 6; i++) begin
         ch[3] = i[0];
         step($sformatf("toggle_d%0d", i));
      end

      // Async reset mid-stream between edges while o=1.
      set_channels(8'hFF);
      sel = 3'd0;
      step("pre_async_high");
      #2;
      rst_n = 1'b0;
      #1;
      check("async_clear", {3'b0, o}, 4'h0);
      #1;
      rst_n = 1'b1;
      #1;
      check("async_release_hold", {3'b0, o}, 4'h0);
      step("async_resume");

      // Randomized registered traffic: sel and data change together.
      for (int i = 0; i < 150; i++) begin
         sel = 3'($urandom_range(0, 7));
         set_channels(8'($urandom));
         step("rand_reg");
      end

      // Combinational variant: directed then random.
      csel   = 3'd5;
      cch[5] = 4'hA;
      #1;
      check("comb_sel5", co, 4'hA);
      for (int i = 0; i < 60; i++) begin
         csel = 3'($urandom_range(0, 7));
         for (int j = 0; j < 8; j++) cch[j] = 4'($urandom);
         #1;
         check("rand_comb", co, cch[csel]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
